seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder.
- Captures a multi-digit hex word through a valid/ready handshake into a shadow register.
- Steps through the digits one at a time, presenting each nibble to the shared decoder and driving that digit's enable.
- Sits between the serial-receive/datapath logic and the board display pins.
- Optionally blanks leading zeros.

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Valid/ready word handshake between the producer (serial-receive or
// datapath logic) and the seg_scan_ctrl display scanner.
//   data_in    : packed hex word, nibble i belongs to digit i (digit 0 rightmost)
//   data_valid : producer holds a word on data_in until it is accepted
//   data_ready : scanner accepts data_in in this cycle
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    data_valid;
    logic                    data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits that
// share one hex-to-segment decoder. A word is captured into a shadow register
// through the bus handshake, and the digits are then lit one at a time for
// TICK_DIV cycles each. Leading zeros can be blanked.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   bus        : word handshake (data_in / data_valid / data_ready)
//   display_en : 0 turns every digit off; scanning carries on underneath
//   nibble_out : nibble for the shared hex-to-segment decoder
//   digit_en_n : active-low anode enables, at most one bit low
//   blank      : 1 forces the segment bus off
//   frame_done : one-cycle pulse after the last digit's slot ends
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word loaded yet; ready always high, display dark
// SCAN  | word loaded; new words accepted only in a frame's last cycle
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_if.slave             bus,
    input  logic                  display_en,
    output logic [3:0]            nibble_out,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  blank,
    output logic                  frame_done
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state_q, state_nxt;
    logic [CW-1:0]           cnt_q, cnt_nxt;
    logic [IW-1:0]           idx_q, idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_nxt;

    logic                    tick, boundary, accept, visible, all_zero;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              nibble_nxt;
    logic [NUM_DIGITS-1:0]   en_n_nxt;

    // Only accepting at the frame boundary keeps a frame from mixing two words.
    assign tick           = (cnt_q == CNT_LAST);
    assign boundary       = tick && (idx_q == IDX_LAST);
    assign bus.data_ready = (state_q == IDLE) || boundary;
    assign accept         = bus.data_valid && bus.data_ready;

    always_comb begin
        state_nxt  = state_q;
        shadow_nxt = shadow_q;
        cnt_nxt    = tick ? '0 : cnt_q + CW'(1);
        idx_nxt    = idx_q;
        if (tick) begin
            idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (accept) begin
            shadow_nxt = bus.data_in;
            // In SCAN the accept already lands on the idx wrap, so only IDLE
            // needs to restart the counters.
            if (state_q == IDLE) begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        end
    end

    // lz_mask[i] is set when nibbles i..top are all zero; digit 0 never blanks.
    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (shadow_nxt[4*i +: 4] == 4'h0);
            lz_mask[i] = all_zero && (LZ_BLANK != 0);
        end
    end

    // Display outputs are built from next-state idx/shadow so they switch on
    // the same edge as the index itself.
    always_comb begin
        nibble_nxt = shadow_nxt[4*idx_nxt +: 4];
        visible    = (state_nxt == SCAN) && display_en && !lz_mask[idx_nxt];
        en_n_nxt   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (visible && (idx_nxt == IW'(i))) begin
                en_n_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            nibble_out <= 4'h0;
            digit_en_n <= '1;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            idx_q      <= idx_nxt;
            shadow_q   <= shadow_nxt;
            nibble_out <= nibble_nxt;
            digit_en_n <= en_n_nxt;
            blank      <= !visible;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       display_en;
    logic [3:0] nib_a, nib_b;
    logic [3:0] en_a, en_b;
    logic       blank_a, blank_b;
    logic       fd_a, fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_if #(.NUM_DIGITS(4)) bus_a();
    seg_scan_if #(.NUM_DIGITS(4)) bus_b();

    seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4), .LZ_BLANK(1)) dut (
        .clk(clk), .reset(reset), .bus(bus_a), .display_en(display_en),
        .nibble_out(nib_a), .digit_en_n(en_a), .blank(blank_a), .frame_done(fd_a)
    );

    seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4), .LZ_BLANK(0)) dut_nl (
        .clk(clk), .reset(reset), .bus(bus_b), .display_en(display_en),
        .nibble_out(nib_b), .digit_en_n(en_b), .blank(blank_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        for (int i = 0; i < 40 && bus_a.data_ready !== 1'b1; i++) step();
        n_cmp++;
        if (bus_a.data_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_ready: data_ready=%b required 1 within 40 cycles", bus_a.data_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        display_en = 1'b1;
        bus_a.data_valid = 1'b0; bus_a.data_in = 16'h0;
        bus_b.data_valid = 1'b0; bus_b.data_in = 16'h0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if ({bus_a.data_ready, blank_a, en_a, nib_a, fd_a} !== {1'b1, 1'b1, 4'b1111, 4'h0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_vals: ready=%b blank=%b en=%b nib=%h fd=%b required 1 1 1111 0 0",
                         bus_a.data_ready, blank_a, en_a, nib_a, fd_a);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if ({bus_a.data_ready, blank_a, en_a} !== {1'b1, 1'b1, 4'b1111}) begin
                n_bad++;
                $display("FAIL idle_dark: ready=%b blank=%b en=%b required 1 1 1111",
                         bus_a.data_ready, blank_a, en_a);
            end
        end
    endtask

    task automatic test_first_load();
        logic [15:0] word = 16'h1A2F;
        logic [3:0]  one  = 4'b0001;
        int d;
        bus_a.data_in = word;
        bus_a.data_valid = 1'b1;
        n_cmp++;
        if (bus_a.data_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL load_ready: ready=%b required 1", bus_a.data_ready);
        end
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            d = (k / 4) % 4;
            n_cmp++;
            if (nib_a !== word[4*d +: 4] || en_a !== ~(one << d) || blank_a !== 1'b0 ||
                fd_a !== (k == 16) || bus_a.data_ready !== ((k % 16) == 15)) begin
                n_bad++;
                $display("FAIL first_load k=%0d: nib=%h en=%b blank=%b fd=%b ready=%b required %h %b 0 %b %b",
                         k, nib_a, en_a, blank_a, fd_a, bus_a.data_ready,
                         word[4*d +: 4], ~(one << d), (k == 16), ((k % 16) == 15));
            end
            step();
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] old_w = 16'h1A2F;
        logic [3:0]  nib_t   [4] = '{4'hE, 4'hE, 4'hB, 4'h0};
        logic [3:0]  en_t    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        logic        blank_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int d;
        for (int k = 32; k < 37; k++) step();
        bus_a.data_in = 16'h0BEE;
        bus_a.data_valid = 1'b1;
        for (int k = 37; k <= 47; k++) begin
            d = (k / 4) % 4;
            n_cmp++;
            if (bus_a.data_ready !== (k == 47) || nib_a !== old_w[4*d +: 4]) begin
                n_bad++;
                $display("FAIL tear_hold k=%0d: ready=%b nib=%h required %b %h",
                         k, bus_a.data_ready, nib_a, (k == 47), old_w[4*d +: 4]);
            end
            if (k < 47) step();
        end
        step();
        bus_a.data_valid = 1'b0;
        bus_a.data_in = 16'h5555;
        for (int k = 0; k < 16; k++) begin
            d = k / 4;
            n_cmp++;
            if (nib_a !== nib_t[d] || en_a !== en_t[d] || blank_a !== blank_t[d]) begin
                n_bad++;
                $display("FAIL tear_new k=%0d: nib=%h en=%b blank=%b required %h %b %b",
                         k, nib_a, en_a, blank_a, nib_t[d], en_t[d], blank_t[d]);
            end
            step();
        end
    endtask

    task automatic test_lz_blank();
        logic [3:0] nib1 [4] = '{4'h0, 4'h3, 4'h0, 4'h0};
        logic [3:0] en1  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic       bl1  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] en2  [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        logic       bl2  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] en3  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int d;
        wait_ready_a();
        bus_a.data_in = 16'h0030; bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d = k / 4;
            n_cmp++;
            if (nib_a !== nib1[d] || en_a !== en1[d] || blank_a !== bl1[d]) begin
                n_bad++;
                $display("FAIL lz_0030 k=%0d: nib=%h en=%b blank=%b required %h %b %b",
                         k, nib_a, en_a, blank_a, nib1[d], en1[d], bl1[d]);
            end
            step();
        end
        wait_ready_a();
        bus_a.data_in = 16'h0000; bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d = k / 4;
            n_cmp++;
            if (nib_a !== 4'h0 || en_a !== en2[d] || blank_a !== bl2[d]) begin
                n_bad++;
                $display("FAIL lz_0000 k=%0d: nib=%h en=%b blank=%b required 0 %b %b",
                         k, nib_a, en_a, blank_a, en2[d], bl2[d]);
            end
            step();
        end
        bus_b.data_in = 16'h0030; bus_b.data_valid = 1'b1;
        n_cmp++;
        if (bus_b.data_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL nl_ready: ready=%b required 1", bus_b.data_ready);
        end
        step();
        bus_b.data_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d = k / 4;
            n_cmp++;
            if (nib_b !== nib1[d] || en_b !== en3[d] || blank_b !== 1'b0) begin
                n_bad++;
                $display("FAIL nolz_0030 k=%0d: nib=%h en=%b blank=%b required %h %b 0",
                         k, nib_b, en_b, blank_b, nib1[d], en3[d]);
            end
            step();
        end
    endtask

    task automatic test_display_en();
        logic [15:0] word = 16'h1A2F;
        logic [3:0]  one  = 4'b0001;
        logic [3:0]  en_exp;
        int d;
        wait_ready_a();
        bus_a.data_in = word; bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        display_en = 1'b0;
        step();
        for (int k = 6; k <= 20; k++) begin
            d = (k / 4) % 4;
            en_exp = (k <= 11) ? 4'b1111 : ~(one << d);
            n_cmp++;
            if (nib_a !== word[4*d +: 4] || en_a !== en_exp || blank_a !== (k <= 11) ||
                fd_a !== (k == 16) || bus_a.data_ready !== (k == 15)) begin
                n_bad++;
                $display("FAIL disp_en k=%0d: nib=%h en=%b blank=%b fd=%b ready=%b required %h %b %b %b %b",
                         k, nib_a, en_a, blank_a, fd_a, bus_a.data_ready,
                         word[4*d +: 4], en_exp, (k <= 11), (k == 16), (k == 15));
            end
            if (k == 11) display_en = 1'b1;
            step();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 21; k < 25; k++) step();
        n_cmp++;
        if (nib_a !== 4'hA || en_a !== 4'b1011) begin
            n_bad++;
            $display("FAIL mid_pre: nib=%h en=%b required a 1011", nib_a, en_a);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({bus_a.data_ready, blank_a, en_a, nib_a, fd_a} !== {1'b1, 1'b1, 4'b1111, 4'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset: ready=%b blank=%b en=%b nib=%h fd=%b required 1 1 1111 0 0",
                     bus_a.data_ready, blank_a, en_a, nib_a, fd_a);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if ({bus_a.data_ready, blank_a, en_a, nib_a} !== {1'b1, 1'b1, 4'b1111, 4'h0}) begin
                n_bad++;
                $display("FAIL post_reset c=%0d: ready=%b blank=%b en=%b nib=%h required 1 1 1111 0",
                         c, bus_a.data_ready, blank_a, en_a, nib_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_tear_free();
        test_lz_blank();
        test_display_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
